ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Fetch stage of the five-stage MIPS pipeline and the consumer of the next-PC value produced by the NPC logic.
- Owns the PC_F register and drives an instruction-memory request/acknowledge handshake with variable latency.
- Buffers the returned word when decode is stalled and delivers PC_D/Instr_D to decode.
- Tells the hazard unit when no instruction is ready.

Parameters:
- PC_INIT, 32'h0000_3000, PC_F value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- NPC  input  32  next PC from the NPC logic; sampled only on an advance cycle.
- stall_D  input  1  hazard-unit stall of the F/D register, excluding fetch_busy. Must not depend combinationally on fetch_busy.
- imem_req  output  1  instruction-memory request valid.
- imem_addr  output  32  word address of the request, {PC_F[31:2],2'b00}.
- imem_ack  input  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  instruction word.
- fetch_busy  output  1  no instruction is ready this cycle; the hazard unit ORs it into the D stall and bubbles E.
- PC_F  output  32  current fetch PC, fed back to the NPC logic.
- PC_D  output  32  PC of the instruction in decode.
- Instr_D  output  32  instruction in decode; 0 (nop) after reset.
- exc_D  output  1  fetch address error on Instr_D. Tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC_F=PC_INIT, PC_D=0, Instr_D=0, exc_D=0, buffer=0.
  - State=WAIT, imem_req=0 while reset is asserted.
- States:
  - WAIT: a request is outstanding. imem_req=1 and imem_addr is held stable until imem_ack.
  - HOLD: the word has been captured in the buffer. imem_req=0.
- ready = (WAIT && imem_ack) || HOLD.
- fetch_busy = !ready (combinational).
- adv = ready && !stall_D.
- On an adv cycle, at the clock edge:
  - Instr_D <= (WAIT ? imem_rdata : buffer).
  - PC_D <= PC_F.
  - PC_F <= NPC.
  - State -> WAIT.
  - The next request for the new PC_F is issued from the following cycle; back-to-back single-cycle acks give 1 instruction per cycle.
- WAIT && imem_ack && stall_D: buffer <= imem_rdata, state -> HOLD. PC_F, PC_D and Instr_D are unchanged.
- HOLD && stall_D: everything holds. No new request is issued; the buffered word is never overwritten.
- WAIT without imem_ack: PC_F, PC_D and Instr_D hold; fetch_busy=1.
- Branch delay slot is implicit:
  - While a branch sits in D, the word at PC_F (branch+4) is the one being fetched.
  - NPC is sampled when that delay-slot word advances into D, i.e. while the branch is still in D.
- An ack on the same cycle the request first asserts (zero wait) is legal.
- A spurious imem_ack in HOLD is ignored.
- Arithmetic: none internally; all PC registers are 32-bit, and NPC is taken verbatim.
- Reset mid-request: the outstanding request is abandoned. The memory must drop it; an ack arriving during reset is ignored.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- With the macro defined, when in WAIT and PC_F[1:0]!=0:
  - imem_req=0; the block is immediately ready (no memory access).
  - On adv: Instr_D <= 0, exc_D <= 1, PC_D <= PC_F, PC_F <= NPC.
  - Every other adv writes exc_D <= 0.
- Without the macro:
  - exc_D is constant 0.
  - PC_F[1:0] is ignored and imem_addr is forced word-aligned.

Test Plan:
- Reset release, zero-wait memory, NPC=PC_F+4, stall_D=0 -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles. PC_D/Instr_D follow one cycle later; fetch_busy=0 throughout.
- Memory acks 3 cycles after the request -> fetch_busy=1 for 3 cycles. imem_addr is held at 0x3004; PC_F/PC_D do not change until the ack cycle.
- Ack arrives with stall_D=1 for 2 cycles, rdata=0x8C010004 -> state HOLD, imem_req=0, fetch_busy=0. After stall_D falls, Instr_D=0x8C010004 and the next request goes to NPC.
- Branch in D at 0x3010, NPC=0x3040 on the delay-slot ack cycle -> Instr_D=word at 0x3014 with PC_D=0x3014, then the next request is issued to 0x3040.
- Reset asserted while in WAIT with a pending request -> PC_F=PC_INIT, Instr_D=0 and imem_req=0 immediately (asynchronously). A late ack during reset is ignored.
- ALIGN_CHECK_EN defined, NPC=0x3022 -> no memory request for 0x3022. Next adv gives exc_D=1, Instr_D=0, PC_D=0x3022. The following aligned fetch clears exc_D.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns PC_F, drives a variable-latency imem handshake and
// buffers the returned word while decode is stalled. Optional macro: ALIGN_CHECK_EN.
module ifu_fetch #(
    parameter logic [31:0] PC_INIT = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] NPC,
    input  logic        stall_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        fetch_busy,
    output logic [31:0] PC_F,
    output logic [31:0] PC_D,
    output logic [31:0] Instr_D,
    output logic        exc_D
);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_f_r;
    logic [31:0] pc_d_r;
    logic [31:0] instr_d_r;
    logic [31:0] buf_r;
    logic [31:0] instr_nxt_s;
    logic        misal_s;
    logic        ready_s;
    logic        adv_s;
    logic        capture_s;

    // Readiness, advance/capture decisions and next state.
    always_comb begin
        misal_s     = 1'b0;
`ifdef ALIGN_CHECK_EN
        misal_s     = (state_r == ST_WAIT) && (pc_f_r[1:0] != 2'b00);
`endif
        ready_s     = 1'b0;
        instr_nxt_s = buf_r;
        state_nxt_s = state_r;
        case (state_r)
            ST_WAIT: begin
                ready_s = imem_ack || misal_s;
                if (misal_s) begin
                    instr_nxt_s = 32'h0000_0000;
                end else begin
                    instr_nxt_s = imem_rdata;
                end
            end
            ST_HOLD: begin
                ready_s     = 1'b1;
                instr_nxt_s = buf_r;
            end
            default: begin
                ready_s     = 1'b0;
                instr_nxt_s = 32'h0000_0000;
            end
        endcase
        adv_s     = ready_s && !stall_D;
        // Misaligned fetches never touch memory, so they have nothing to buffer.
        capture_s = (state_r == ST_WAIT) && imem_ack && !misal_s && stall_D;
        if (adv_s) begin
            state_nxt_s = ST_WAIT;
        end else if (capture_s) begin
            state_nxt_s = ST_HOLD;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State register plus PC_F, F/D pipeline register and the hold buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_WAIT;
            pc_f_r    <= PC_INIT;
            pc_d_r    <= 32'h0000_0000;
            instr_d_r <= 32'h0000_0000;
            buf_r     <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            if (adv_s) begin
                instr_d_r <= instr_nxt_s;
                pc_d_r    <= pc_f_r;
                pc_f_r    <= NPC;
            end
            if (capture_s) begin
                buf_r <= imem_rdata;
            end
        end
    end

`ifdef ALIGN_CHECK_EN
    logic exc_d_r;

    // Address-error flag travels with the instruction into decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_d_r <= 1'b0;
        end else if (adv_s) begin
            exc_d_r <= misal_s;
        end
    end

    assign exc_D = exc_d_r;
`else
    assign exc_D = 1'b0;
`endif

    // Request is gated by reset so an abandoned request drops immediately.
    assign imem_req   = reset && (state_r == ST_WAIT) && !misal_s;
    assign imem_addr  = {pc_f_r[31:2], 2'b00};
    assign fetch_busy = !ready_s;
    assign PC_F       = pc_f_r;
    assign PC_D       = pc_d_r;
    assign Instr_D    = instr_d_r;

endmodule
